// File: rtl/atm_pkg.sv
// Shared types and constants for the multi-account ATM controller.
package atm_pkg;

  // Session states.
  typedef enum logic [2:0] {
    IDLE,
    PIN_WAIT,
    MENU,
    EXEC,
    DONE
  } state_t;

  // Operation codes carried on op_code.
  localparam logic [1:0] OP_CHPIN = 2'b00;
  localparam logic [1:0] OP_BAL   = 2'b01;
  localparam logic [1:0] OP_DEP   = 2'b10;
  localparam logic [1:0] OP_WDR   = 2'b11;

endpackage

// File: rtl/atm_timeout_counter.sv
// Inactivity timer: counts enabled cycles since the last clear and flags the
// cycle in which the count would reach TIMEOUT_CYCLES. A clear in that same
// cycle suppresses the expiry.
module atm_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  // Idle-cycle counter; cleared by any activity or outside the timed states.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/atm_multi_account.sv
// Multi-account ATM session controller with per-account balance/PIN storage,
// PIN retry locking, inactivity timeout and a per-session withdrawal cap.
module atm_multi_account
  import atm_pkg::*;
#(
  parameter int               NUM_ACCOUNTS   = 4,
  parameter int               PIN_W          = 4,
  parameter int               AMT_W          = 20,
  parameter int               BAL_W          = 32,
  parameter logic [PIN_W-1:0] DEFAULT_PIN    = 4'b1010,
  parameter int               MAX_TRIES      = 3,
  parameter int               TIMEOUT_CYCLES = 16,
  parameter logic [AMT_W-1:0] WITHDRAW_LIMIT = 20'h01000,
  localparam int              AW = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_in,
  input  logic [AW-1:0]    account_id,
  input  logic [PIN_W-1:0] pin,
  input  logic             pin_valid,
  input  logic [1:0]       op_code,
  input  logic             op_valid,
  input  logic [AMT_W-1:0] amount,
  input  logic             eject_card,
  output logic             correct_password,
  output logic             balance_shown,
  output logic             deposited_ok,
  output logic             withdrawn_ok,
  output logic             pin_changed,
  output logic             op_error,
  output logic             card_locked,
  output logic             timeout,
  output logic             usage_finished,
  output logic [BAL_W-1:0] current_balance
);

  localparam int              TW       = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0]   LAST_TRY = TW'(MAX_TRIES - 1);

  state_t state_q, state_d;

  // Account storage and session context.
  logic [BAL_W-1:0]        bal_q [NUM_ACCOUNTS];
  logic [BAL_W-1:0]        bal_d [NUM_ACCOUNTS];
  logic [PIN_W-1:0]        pin_q [NUM_ACCOUNTS];
  logic [PIN_W-1:0]        pin_d [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_q, lock_d;
  logic [AW-1:0]           acct_q, acct_d;
  logic [1:0]              op_q, op_d;
  logic [AMT_W-1:0]        amt_q, amt_d;
  logic [TW-1:0]           tries_q, tries_d;
  logic [AMT_W-1:0]        sess_wd_q, sess_wd_d;

  // Next values of the registered outputs.
  logic             cp_d, shown_d, dep_ok_d, wdr_ok_d, pin_chg_d, err_d, lock_pulse_d;
  logic             tmo_d, usage_d;
  logic [BAL_W-1:0] cur_bal_d;

  // Shared decode.
  logic             session_end, pin_ok, last_try, expired, timer_clear, timer_en;
  logic [BAL_W-1:0] cur_bal;
  logic [BAL_W:0]   dep_sum;
  logic [AMT_W:0]   wdr_sum;
  logic             dep_ok, wdr_ok;

  assign session_end = eject_card || !card_in;
  assign pin_ok      = (pin == pin_q[acct_q]);
  assign last_try    = (tries_q == LAST_TRY);
  assign cur_bal     = bal_q[acct_q];
  assign dep_sum     = {1'b0, cur_bal} + (BAL_W + 1)'(amt_q);
  assign wdr_sum     = {1'b0, sess_wd_q} + {1'b0, amt_q};
  assign dep_ok      = (amt_q != '0) && !dep_sum[BAL_W];
  assign wdr_ok      = (amt_q != '0) && (BAL_W'(amt_q) <= cur_bal) &&
                       (wdr_sum <= {1'b0, WITHDRAW_LIMIT});

  // The timer only runs while waiting on the user; any other state holds it at
  // zero, so entering PIN_WAIT or MENU always starts from a fresh count.
  assign timer_en    = (state_q == PIN_WAIT) || (state_q == MENU);
  assign timer_clear = !timer_en || pin_valid || op_valid;

  atm_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of block ordering.
      state_q <= state_d;
    end
  end

  // Next-state logic: session end beats strobes, strobes beat the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (card_in) state_d = lock_q[account_id] ? DONE : PIN_WAIT;
      PIN_WAIT: begin
        if (session_end)    state_d = DONE;
        else if (pin_valid) state_d = pin_ok ? MENU : (last_try ? DONE : PIN_WAIT);
        else if (expired)   state_d = DONE;
      end
      MENU: begin
        if (session_end)    state_d = DONE;
        else if (op_valid)  state_d = EXEC;
        else if (expired)   state_d = DONE;
      end
      EXEC:     state_d = MENU;
      DONE:     if (!card_in) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output and datapath logic: computes the next value of every register.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    bal_d        = bal_q;
    pin_d        = pin_q;
    lock_d       = lock_q;
    acct_d       = acct_q;
    op_d         = op_q;
    amt_d        = amt_q;
    tries_d      = tries_q;
    sess_wd_d    = sess_wd_q;
    shown_d      = 1'b0;
    dep_ok_d     = 1'b0;
    wdr_ok_d     = 1'b0;
    pin_chg_d    = 1'b0;
    err_d        = 1'b0;
    lock_pulse_d = 1'b0;
    tmo_d        = expired && !session_end;
    unique case (state_q)
      IDLE: if (card_in) begin
        acct_d       = account_id;
        tries_d      = '0;
        lock_pulse_d = lock_q[account_id];
      end
      PIN_WAIT: if (!session_end && pin_valid) begin
        if (pin_ok) begin
          sess_wd_d = '0;
        end else if (last_try) begin
          lock_d[acct_q] = 1'b1;
          lock_pulse_d   = 1'b1;
        end else begin
          tries_d = tries_q + TW'(1);
        end
      end
      MENU: if (!session_end && op_valid) begin
        op_d  = op_code;
        amt_d = amount;
      end
      EXEC: begin
        unique case (op_q)
          OP_CHPIN: begin
            pin_d[acct_q] = amt_q[PIN_W-1:0];
            pin_chg_d     = 1'b1;
          end
          OP_BAL: shown_d = 1'b1;
          OP_DEP: begin
            if (dep_ok) begin
              bal_d[acct_q] = dep_sum[BAL_W-1:0];
              dep_ok_d      = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_WDR: begin
            if (wdr_ok) begin
              bal_d[acct_q] = cur_bal - BAL_W'(amt_q);
              sess_wd_d     = wdr_sum[AMT_W-1:0];
              wdr_ok_d      = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    cp_d      = (state_d == MENU) || (state_d == EXEC);
    usage_d   = (state_d == DONE);
    cur_bal_d = cp_d ? bal_d[acct_d] : '0;
  end

  // Storage, session context and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: account storage is reset on purpose; a reset wipes all balances
      // and restores the default PIN, so the arrays cannot map to plain RAM.
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal_q[i] <= '0;
        pin_q[i] <= DEFAULT_PIN;
      end
      lock_q           <= '0;
      acct_q           <= '0;
      op_q             <= '0;
      amt_q            <= '0;
      tries_q          <= '0;
      sess_wd_q        <= '0;
      correct_password <= 1'b0;
      balance_shown    <= 1'b0;
      deposited_ok     <= 1'b0;
      withdrawn_ok     <= 1'b0;
      pin_changed      <= 1'b0;
      op_error         <= 1'b0;
      card_locked      <= 1'b0;
      timeout          <= 1'b0;
      usage_finished   <= 1'b0;
      current_balance  <= '0;
    end else begin
      bal_q            <= bal_d;
      pin_q            <= pin_d;
      lock_q           <= lock_d;
      acct_q           <= acct_d;
      op_q             <= op_d;
      amt_q            <= amt_d;
      tries_q          <= tries_d;
      sess_wd_q        <= sess_wd_d;
      correct_password <= cp_d;
      balance_shown    <= shown_d;
      deposited_ok     <= dep_ok_d;
      withdrawn_ok     <= wdr_ok_d;
      pin_changed      <= pin_chg_d;
      op_error         <= err_d;
      card_locked      <= lock_pulse_d;
      timeout          <= tmo_d;
      usage_finished   <= usage_d;
      current_balance  <= cur_bal_d;
    end
  end

endmodule

// File: doc/atm_multi_account.md
Name: atm_multi_account

Overview:
Parameterised successor to the single-account ATM controller. It serves NUM_ACCOUNTS accounts and keeps a per-account balance and PIN register file. It adds PIN retry limiting with account lock, an internal inactivity timeout, a per-session withdrawal cap, overflow and insufficient-funds rejection, and a change-PIN operation. It sits between the card/keypad front end and the cash/display back end.

Parameters:
NUM_ACCOUNTS, 4, number of accounts; AW = max(1, $clog2(NUM_ACCOUNTS))
PIN_W, 4, PIN width
AMT_W, 20, transaction amount width
BAL_W, 32, balance width (BAL_W >= AMT_W)
DEFAULT_PIN, 4'b1010, PIN of every account after reset
MAX_TRIES, 3, wrong PIN entries allowed before lock
TIMEOUT_CYCLES, 16, idle cycles in PIN_WAIT/MENU before forced end of session
WITHDRAW_LIMIT, 20'h01000, cumulative withdrawal cap per session

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
card_in  in  1  card present level
account_id  in  AW  account selected; sampled on card insertion
pin  in  PIN_W  entered PIN
pin_valid  in  1  one-cycle strobe, pin is valid
op_code  in  2  00 change PIN, 01 show balance, 10 deposit, 11 withdraw
op_valid  in  1  one-cycle strobe, op_code/amount valid
amount  in  AMT_W  deposit/withdraw amount; new PIN in amount[PIN_W-1:0]
eject_card  in  1  user ends session
correct_password  out  1  level, high from PIN accept until DONE
balance_shown  out  1  pulse
deposited_ok  out  1  pulse
withdrawn_ok  out  1  pulse
pin_changed  out  1  pulse
op_error  out  1  pulse: rejected operation
card_locked  out  1  pulse: account locked or already locked
timeout  out  1  pulse: inactivity timeout
usage_finished  out  1  level, high while in DONE
current_balance  out  BAL_W  balance of the session account while correct_password is high, else 0

Behaviour:
- Reset: state IDLE. Every balance = 0, every PIN = DEFAULT_PIN, lock flags = 0, tries = 0, session_withdrawn = 0. All outputs = 0. Reset mid-session clears everything, including account storage.
- Outputs are registered. Pulses are exactly one cycle.
- IDLE: on card_in=1, latch account_id. If the account is locked, pulse card_locked and go to DONE. Otherwise go to PIN_WAIT with tries = 0 and timer cleared.
- PIN_WAIT, on pin_valid:
  - Match: correct_password = 1, session_withdrawn = 0, go to MENU.
  - Mismatch: tries++. When tries reaches MAX_TRIES, set the lock flag, pulse card_locked and go to DONE.
- MENU, on op_valid: latch op_code and amount, go to EXEC. On the next edge, perform the operation, pulse exactly one result flag and return to MENU. Latency from op_valid sample to flag/balance update is 2 edges.
- Change PIN: PIN = amount[PIN_W-1:0]; pulse pin_changed.
- Show balance: pulse balance_shown.
- Deposit: reject (op_error, balance unchanged) if amount = 0 or balance + amount exceeds 2^BAL_W - 1, computed in BAL_W+1 bits. Otherwise balance += amount and pulse deposited_ok.
- Withdraw: reject if amount = 0, amount > balance, or session_withdrawn + amount > WITHDRAW_LIMIT (computed in AMT_W+1 bits). Otherwise balance -= amount, session_withdrawn += amount, pulse withdrawn_ok.
- op_valid while in EXEC is ignored.
- Timeout: counter clears on entering PIN_WAIT/MENU and on any pin_valid or op_valid. When it reaches TIMEOUT_CYCLES in PIN_WAIT or MENU, pulse timeout and go to DONE. A strobe in the same cycle as expiry wins (counter clears, no timeout).
- Session end: eject_card=1 or card_in=0 in PIN_WAIT or MENU goes to DONE. Eject beats a simultaneous op_valid or pin_valid. An in-flight EXEC always completes first.
- DONE: correct_password = 0, usage_finished = 1. Return to IDLE only once card_in = 0, so one insertion is exactly one session.
- Lock flags persist until reset. tries is per-session and is not retained after a session ends.

Decomposition:
- Package atm_pkg: state enum (IDLE, PIN_WAIT, MENU, EXEC, DONE) and opcode constants OP_CHPIN/OP_BAL/OP_DEP/OP_WDR.
- One sub-module, atm_timeout_counter: parameter TIMEOUT_CYCLES; inputs clk, reset, clear, enable; output expired pulse.

Test Plan:
- Account 2, PIN 1010, deposit 0x00488 -> deposited_ok 2 edges after op_valid; current_balance = 0x488. Eject -> usage_finished=1; card_in=0 -> IDLE.
- Account 2 with balance 0x488: withdraw 0x100 -> withdrawn_ok, balance 0x388. Withdraw 0x400 -> op_error, balance 0x388. Accounts 0/1/3 stay 0.
- Session with WITHDRAW_LIMIT=0x1000 and balance 0x3000: withdraw 0xF00 ok; then withdraw 0x200 -> op_error. New session: withdraw 0x200 -> ok.
- Wrong PIN 0000 three times on account 1 -> card_locked on the 3rd entry, DONE. Reinsert account 1 with correct PIN -> card_locked immediately, correct_password never high.
- Change PIN to 0x5 -> pin_changed. New session: 1010 rejected, 0101 accepted. No input for 16 cycles in MENU -> timeout pulse, correct_password=0.
- Balance 0xFFFFFF00, deposit 0x200 -> op_error, balance unchanged. Reset asserted during EXEC -> all outputs 0 and balances 0 on the next edge.
